keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 hex matrix keypad and turns one debounced key press into exactly one registered hex digit. It sits on the input side of the board, opposite the multiplexed seven-segment display driver. The display driver time-multiplexes outputs; this block time-multiplexes keypad rows. It keeps a two-digit history (`digit_new`, `digit_old`) that feeds straight into the display's two 4-bit digit inputs.

## Interface
- `SCAN_DIV`, default 12_000: clock cycles each row stays driven while scanning (1 ms at 12 MHz).
- `DEBOUNCE_CYCLES`, default 240_000: clock cycles a pattern must stay stable to accept a press or a release (20 ms at 12 MHz).

Ports:
- `clk` in 1: system clock, 12 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `cols` in 4: keypad column lines.
  - Active-low with external pull-ups.
  - Asynchronous to `clk`.
- `rows` out 4: keypad row drives, active-low, exactly one bit low at all times.
- `key_valid` out 1: one-cycle pulse marking an accepted press.
- `key_code` out 4: hex code of the last accepted key.
- `digit_new` out 4: most recently accepted digit.
- `digit_old` out 4: digit accepted before `digit_new`.

## Operation
- `cols` passes through a two-flop synchronizer; all logic uses the synchronized value `cs`.
- Key map as (row, col 0..3):
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = E 0 F D
- Row index `r` (2 bits) drives `rows = ~(1 << r)`.
- Dwell counter `dc` counts 0..SCAN_DIV-1 in SCAN.
- Debounce counter `bc` counts 0..DEBOUNCE_CYCLES-1 in DEBOUNCE and RELEASE.
- FSM states:
  - SCAN:
    - `dc` counts up each cycle.
    - On `dc == SCAN_DIV-1`, sample `cs`:
      - Exactly one bit low: latch `cap = cs` and `(r, col)`, clear `bc`, go to DEBOUNCE. `r` stays frozen.
      - Zero bits low, or more than one: `r <= r+1` (wraps 3 -> 0), clear `dc`.
  - DEBOUNCE:
    - `r` frozen; `bc` increments each cycle.
    - If `cs != cap` on any cycle: go to SCAN with `r <= r+1` and `dc` cleared.
    - If `bc == DEBOUNCE_CYCLES-1` and `cs == cap`, all on one edge:
      - `key_valid <= 1`
      - `key_code <= map(r, col)`
      - `digit_old <= digit_new`
      - `digit_new <= map(r, col)`
      - go to HELD.
  - HELD:
    - `r` frozen.
    - When `cs == 4'b1111`: clear `bc`, go to RELEASE.
    - Any other pattern keeps HELD with no output, including a second key in the same row.
    - Keys in other rows are invisible here because `r` is frozen.
  - RELEASE:
    - `r` frozen; `bc` increments while `cs == 4'b1111`.
    - Any low bit: return to HELD.
    - When `bc == DEBOUNCE_CYCLES-1`: go to SCAN with `r <= r+1` and `dc` cleared.
- `key_valid` is high in exactly one cycle per press and is 0 otherwise.
- Reset values:
  - State: SCAN.
  - `r` = 0, so `rows = 4'b1110`.
  - `dc`, `bc` = 0.
  - Synchronizer flops = 4'b1111.
  - `key_valid` = 0.
  - `key_code`, `digit_new`, `digit_old` = 0.
- Reset asserted mid-debounce or while held: all of the above take effect immediately, with no pulse. After reset, a key still held is re-detected from SCAN and is accepted once.

## Timing
- All outputs are registered; none is combinational from `cols`.
- Synchronizer latency: 2 cycles from a `cols` change to `cs`.
- Row settling: `cs` is sampled only at the last cycle of each dwell, giving SCAN_DIV-2 cycles of settling.
- Press latency: the sample cycle T detects the key. `key_valid` is high in cycle T+DEBOUNCE_CYCLES, and the digits update on that same edge.
- Worst-case detection delay: 4·SCAN_DIV + DEBOUNCE_CYCLES + 2 cycles.
- Minimum time between accepted presses: DEBOUNCE_CYCLES (release) + DEBOUNCE_CYCLES (press) + the scan time.
- Counter widths: `dc` is $clog2(SCAN_DIV) bits and `bc` is $clog2(DEBOUNCE_CYCLES) bits. Neither counter wraps past its terminal value.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_CYCLES=8, and model the keypad as `cols[c] = 0` iff key (r, c) is pressed and `rows[r] == 0`.

- **Reset:** hold `reset=0` for 3 cycles, then release with no key pressed.
  - `rows` must be 1110 during reset.
  - `rows` then cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110 every 4 cycles.
  - `key_valid` stays 0; all digits stay 0.
- **Clean press:** press '5' (r1, c1) for 200 cycles.
  - Exactly one `key_valid` pulse, with `key_code` = 5, `digit_new` = 5, `digit_old` = 0.
  - `rows` stays 1101 while the key is held; no second pulse.
- **Bounce:** toggle '9' every 3 cycles for 30 cycles, then hold it stable for 50 cycles.
  - Exactly one pulse, `key_code` = 9.
- **Sequence:** press and release '3', then press and release 'D'.
  - Two pulses total; final `digit_new` = D, `digit_old` = 3.
- **Second key while held:** hold 'B' (r1, c3), press '4' (r1, c0) and '8' (r2, c1), then release all.
  - Only the 'B' pulse appears.
  - A later press of '8' alone gives one pulse, `digit_new` = 8.
- **Reset mid-debounce:** assert reset 3 cycles after '7' is detected.
  - All outputs return to reset values immediately; no pulse during reset.
  - After reset releases with '7' still held: one pulse, `digit_new` = 7.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: rotates an active-low row drive, debounces one key
// and emits a single registered hex digit per press, with a two-digit history.
module keypad_scanner #(
  parameter int SCAN_DIV        = 12_000,
  parameter int DEBOUNCE_CYCLES = 240_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int DC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(SCAN_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [3:0]      sync1_r;
  logic [3:0]      cs_r;
  logic [3:0]      cap_r;
  logic [1:0]      r_r;
  logic [1:0]      col_r;
  logic [DC_W-1:0] dc_r;
  logic [BC_W-1:0] bc_r;

  function automatic logic one_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] col_of(input logic [3:0] v);
    case (v)
      4'b1110: col_of = 2'd0;
      4'b1101: col_of = 2'd1;
      4'b1011: col_of = 2'd2;
      default: col_of = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;
      4'h1: key_map = 4'h2;
      4'h2: key_map = 4'h3;
      4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;
      4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h6;
      4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;
      4'h9: key_map = 4'h8;
      4'hA: key_map = 4'h9;
      4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;
      4'hD: key_map = 4'h0;
      4'hE: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  // Two-flop synchronizer; idle (all released) value is all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 4'b1111;
      cs_r    <= 4'b1111;
    end else begin
      sync1_r <= cols;
      cs_r    <= sync1_r;
    end
  end

  // Scan / debounce / hold / release FSM; rows is kept as a rotating one-cold copy of r_r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= SCAN;
      r_r       <= 2'd0;
      rows      <= 4'b1110;
      col_r     <= 2'd0;
      cap_r     <= 4'b1111;
      dc_r      <= '0;
      bc_r      <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      case (state_r)
        SCAN: begin
          if (dc_r == DC_LAST) begin
            if (one_low(cs_r)) begin
              cap_r   <= cs_r;
              col_r   <= col_of(cs_r);
              bc_r    <= '0;
              state_r <= DEBOUNCE;
            end else begin
              r_r  <= r_r + 2'd1;
              rows <= {rows[2:0], rows[3]};
              dc_r <= '0;
            end
          end else begin
            dc_r <= dc_r + DC_ONE;
          end
        end
        DEBOUNCE: begin
          if (cs_r != cap_r) begin
            r_r     <= r_r + 2'd1;
            rows    <= {rows[2:0], rows[3]};
            dc_r    <= '0;
            state_r <= SCAN;
          end else if (bc_r == BC_LAST) begin
            key_valid <= 1'b1;
            key_code  <= key_map(r_r, col_r);
            digit_old <= digit_new;
            digit_new <= key_map(r_r, col_r);
            state_r   <= HELD;
          end else begin
            bc_r <= bc_r + BC_ONE;
          end
        end
        HELD: begin
          if (cs_r == 4'b1111) begin
            bc_r    <= '0;
            state_r <= RELEASE;
          end else begin
            state_r <= HELD;
          end
        end
        RELEASE: begin
          if (cs_r != 4'b1111) begin
            state_r <= HELD;
          end else if (bc_r == BC_LAST) begin
            r_r     <= r_r + 2'd1;
            rows    <= {rows[2:0], rows[3]};
            dc_r    <= '0;
            state_r <= SCAN;
          end else begin
            bc_r <= bc_r + BC_ONE;
          end
        end
        default: begin
          state_r <= SCAN;
          dc_r    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives cols from rows, and a
// scoreboard queue holds the digit each press should produce.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  logic [15:0] pressed;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] code;
    logic [3:0] dnew;
    logic [3:0] dold;
  } exp_t;
  exp_t exp_q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows), .key_valid(key_valid),
    .key_code(key_code), .digit_new(digit_new), .digit_old(digit_old)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low when its row is driven.
  always_comb begin
    cols = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[r*4+c] && rows[r] == 1'b0) cols[c] = 1'b0;
  end

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] code, input logic [3:0] dold);
    exp_t e;
    e.code = code; e.dnew = code; e.dold = dold;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_drained(input string tag);
    check4(tag, 4'(exp_q.size()), 4'd0);
  endtask

  // Pulse monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (key_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check4("unexpected_pulse", {3'b000, key_valid}, 4'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check4("key_code", key_code, e.code);
        check4("digit_new", digit_new, e.dnew);
        check4("digit_old", digit_old, e.dold);
      end
    end
  end

  initial begin
    logic [3:0] one;
    int n;
    one = 4'b0001;
    pressed = 16'h0000;
    reset = 1'b0;

    // Reset: rows held at 1110, outputs zero
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check4("rows_in_reset", rows, 4'b1110);
    end
    check4("key_valid_reset", {3'b000, key_valid}, 4'd0);
    check4("digit_new_reset", digit_new, 4'h0);
    check4("digit_old_reset", digit_old, 4'h0);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check4("rows_scan", rows, ~(one << ((k / 4) % 4)));
    end
    check4("key_code_idle", key_code, 4'h0);
    check4("digit_new_idle", digit_new, 4'h0);

    // Clean press of '5'
    expect_key(4'h5, 4'h0);
    pressed[1*4+1] = 1'b1;
    cycles(100);
    check4("rows_frozen_5", rows, 4'b1101);
    cycles(100);
    pressed = 16'h0000;
    cycles(40);
    check_drained("pulses_5");

    // Bouncing '9', then stable
    expect_key(4'h9, 4'h5);
    for (int i = 0; i < 10; i++) begin
      pressed[2*4+2] = ~pressed[2*4+2];
      cycles(3);
    end
    pressed[2*4+2] = 1'b1;
    cycles(50);
    pressed = 16'h0000;
    cycles(40);
    check_drained("pulses_9");

    // Sequence '3' then 'D'
    expect_key(4'h3, 4'h9);
    pressed[0*4+2] = 1'b1;
    cycles(60);
    pressed = 16'h0000;
    cycles(40);
    check_drained("pulses_3");
    expect_key(4'hD, 4'h3);
    pressed[3*4+3] = 1'b1;
    cycles(60);
    pressed = 16'h0000;
    cycles(40);
    check_drained("pulses_D");
    check4("seq_digit_new", digit_new, 4'hD);
    check4("seq_digit_old", digit_old, 4'h3);

    // Hold 'B', add '4' (same row) and '8' (other row)
    expect_key(4'hB, 4'hD);
    pressed[1*4+3] = 1'b1;
    cycles(60);
    check_drained("pulses_B");
    pressed[1*4+0] = 1'b1;
    pressed[2*4+1] = 1'b1;
    cycles(40);
    check4("rows_frozen_B", rows, 4'b1101);
    pressed = 16'h0000;
    cycles(40);
    check_drained("pulses_B_extra");
    expect_key(4'h8, 4'hB);
    pressed[2*4+1] = 1'b1;
    cycles(60);
    pressed = 16'h0000;
    cycles(40);
    check_drained("pulses_8");
    check4("digit_new_8", digit_new, 4'h8);
    check4("key_code_8", key_code, 4'h8);

    // Reset 3 cycles after '7' is detected
    n = 0;
    while (rows !== 4'b1101 && n < 40) begin @(negedge clk); n++; end
    check4("wait_row1", rows, 4'b1101);
    pressed[2*4+0] = 1'b1;
    n = 0;
    while (rows !== 4'b1011 && n < 40) begin @(negedge clk); n++; end
    check4("wait_row2", rows, 4'b1011);
    cycles(4);
    cycles(3);
    reset = 1'b0;
    #1;
    check4("rst_rows", rows, 4'b1110);
    check4("rst_key_valid", {3'b000, key_valid}, 4'd0);
    check4("rst_key_code", key_code, 4'h0);
    check4("rst_digit_new", digit_new, 4'h0);
    check4("rst_digit_old", digit_old, 4'h0);
    cycles(3);
    reset = 1'b1;
    expect_key(4'h7, 4'h0);
    cycles(60);
    check_drained("pulses_7");
    pressed = 16'h0000;
    cycles(40);
    check4("digit_new_7", digit_new, 4'h7);
    check4("digit_old_7", digit_old, 4'h0);
    check_drained("pulses_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
